tcm_responder: RTL and testbench
================================

Name: tcm_responder

Overview:
- Memory-side responder for the core memory request interface (valid/instr/mode/addr/wdata/wstrb in; ready/rdata/error out).
- Sits downstream of the PMP checker.
- Serves instruction and data requests from an internal word-addressed tightly-coupled RAM, with a programmable wait-state count.
- Reports bus errors for out-of-range and misaligned accesses.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be DEPTH*4 aligned.
- DEPTH, 1024, number of 32-bit words; power of two, minimum 4.
- WAIT_CYCLES, 0, extra cycles between accept and response (0..15).
- GUARD_WORDS, 16, size of the guarded low region; used only with TCM_UMODE_GUARD_EN.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  request strobe
- mem_instr  in  1  1 = instruction fetch; 0 = data access
- mem_mode  in  2  privilege of requester (2'b11 = machine)
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write enables; all-zero = read
- mem_ready  out  1  one-cycle response pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- mem_error  out  1  error flag, valid while mem_ready=1

Behaviour:
- Reset (clock edge with reset=1):
  - state=IDLE; mem_ready=0, mem_rdata=0, mem_error=0; wait counter=0; pending request dropped.
  - RAM contents are not cleared.
  - Reset in WAIT: no write is committed and no response is issued.
- States:
  - IDLE -> WAIT on mem_valid=1 and WAIT_CYCLES>0.
  - IDLE -> RESP on mem_valid=1 and WAIT_CYCLES=0.
  - WAIT -> RESP when counter reaches WAIT_CYCLES-1.
  - RESP -> IDLE unconditionally.
- Accept (IDLE, mem_valid=1): capture instr, mode, addr, wdata, wstrb; counter=0.
- Busy (WAIT/RESP): mem_valid is ignored and not queued. The requester re-presents the request after mem_ready.
- Latency: accept at edge N; mem_ready=1 for exactly the cycle after edge N+1+WAIT_CYCLES. Back-to-back rate is one request per WAIT_CYCLES+2 cycles.
- Error checks on the captured request, evaluated at entry to RESP:
  - Out of range: addr < BASE_ADDR or addr >= BASE_ADDR+DEPTH*4, computed in 33-bit arithmetic so there is no wrap at 0xFFFF_FFFF.
  - Misaligned: addr[1:0] != 0.
  - Store marked as fetch: mem_instr=1 with wstrb != 0.
- On error: mem_error=1, mem_rdata=0, no RAM write.
- On a good read: mem_rdata = RAM[(addr-BASE_ADDR)>>2], mem_error=0.
- On a good write:
  - Each byte lane k with wstrb[k]=1 is updated from wdata[8k+7:8k]; other lanes are unchanged.
  - mem_rdata=0, mem_error=0.
  - The write commits on the same edge that raises mem_ready.
- Outside RESP: mem_ready=0, mem_rdata=0, mem_error=0.
- mem_mode is stored but otherwise unused unless the optional feature is enabled.

Optional Feature:
- Macro: TCM_UMODE_GUARD_EN.
- Defined: an extra error condition applies. A data write (mem_instr=0, wstrb!=0) with mem_mode != 2'b11 to a word index < GUARD_WORDS sets mem_error=1 and performs no write. Reads and fetches to the guarded region are unaffected.
- Undefined: mem_mode has no effect and GUARD_WORDS is unused.

Test Plan:
- WAIT_CYCLES=2, after reset: write 0xDEADBEEF to BASE+0x10 with wstrb=4'hF -> mem_ready pulses 4 cycles after accept, error=0. Then read BASE+0x10 -> rdata=0xDEADBEEF.
- Byte strobes: word holds 0x11223344; write 0xAABBCCDD with wstrb=4'b0101 -> readback 0x11BB33DD.
- Errors:
  - Read BASE+DEPTH*4 -> error=1, rdata=0.
  - Read BASE+0x2 -> error=1.
  - Fetch with wstrb=4'h1 -> error=1 and the RAM word is unchanged.
  - Address 0xFFFF_FFFC with BASE=0 -> error=1 (no wrap).
- Busy ignore: hold mem_valid high with a new address during WAIT -> only the first request is answered; the next accept happens in the cycle after the mem_ready pulse.
- Reset in WAIT: write 0x12345678 accepted, reset asserted one cycle later -> no mem_ready. Subsequent read returns the old contents.
- TCM_UMODE_GUARD_EN: mode=2'b00 write to word 3 -> error=1, word unchanged. mode=2'b11 write to word 3 -> success. mode=2'b00 write to word GUARD_WORDS -> success.

Source files
------------

// File: rtl/tcm_responder.sv
// rtl/tcm_responder.sv - tightly-coupled RAM responder with wait states and bus-error reporting
// Optional: TCM_UMODE_GUARD_EN blocks non-machine data writes to the low GUARD_WORDS words.
module tcm_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter int          GUARD_WORDS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [1:0]  mem_mode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_instr;
  logic [1:0]  r_mode;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [31:0] r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_range_err;
  logic          w_align_err;
  logic          w_fetch_err;
  logic          w_guard_err;
  logic          w_err;
  logic          w_do_write;

  // BASE_ADDR is DEPTH*4 aligned, so the word index is just the low address bits.
  assign w_idx       = r_addr[AW+1:2];
  assign w_range_err = ({1'b0, r_addr} < {1'b0, BASE_ADDR}) || ({1'b0, r_addr} >= LIMIT);
  assign w_align_err = (r_addr[1:0] != 2'b00);
  assign w_fetch_err = r_instr && (r_wstrb != 4'h0);

`ifdef TCM_UMODE_GUARD_EN
  assign w_guard_err = !r_instr && (r_wstrb != 4'h0) && (r_mode != 2'b11) &&
                       (32'(w_idx) < 32'(GUARD_WORDS));
`else
  logic w_unused_mode;
  assign w_unused_mode = ^r_mode ^ (GUARD_WORDS > 0);
  assign w_guard_err   = 1'b0;
`endif

  assign w_err      = w_range_err || w_align_err || w_fetch_err || w_guard_err;
  assign w_do_write = (r_state == S_RESP) && !reset && !w_err && (r_wstrb != 4'h0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
      r_error <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_valid) begin
            r_instr <= mem_instr;
            r_mode  <= mem_mode;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_cnt   <= 4'd0;
            r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'(WAIT_CYCLES - 1)) r_state <= S_RESP;
          else                              r_cnt   <= r_cnt + 4'd1;
        end
        S_RESP: begin
          r_ready <= 1'b1;
          r_error <= w_err;
          r_rdata <= (!w_err && r_wstrb == 4'h0) ? r_mem[w_idx] : 32'h0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM survives reset; the write lands on the edge that raises mem_ready.
  always_ff @(posedge clock) begin
    if (w_do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (r_wstrb[k]) r_mem[w_idx][8*k +: 8] <= r_wdata[8*k +: 8];
      end
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign mem_error = r_error;

endmodule

// File: tb/tb_tcm_responder.sv
// tb/tb_tcm_responder.sv - directed self-checking bench for tcm_responder (WAIT_CYCLES=2)
module tb_tcm_responder;

  localparam int WAITS = 2;
  localparam int LAT   = WAITS + 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic [1:0]  mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;

  int n_checks = 0;
  int n_errors = 0;

  tcm_responder #(
    .BASE_ADDR   (32'h0000_0000),
    .DEPTH       (1024),
    .WAIT_CYCLES (WAITS),
    .GUARD_WORDS (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_mode  (mem_mode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_error (mem_error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge, drop it after accept, count negedges to mem_ready.
  task automatic do_req(input logic instr, input logic [1:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        output logic [31:0] rdata, output logic err, output int lat);
    mem_valid = 1'b1; mem_instr = instr; mem_mode = mode;
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    @(posedge clock); #1;
    mem_valid = 1'b0;
    lat = 0; rdata = 32'hX; err = 1'bX;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      if (mem_ready) begin
        lat = c; rdata = mem_rdata; err = mem_error;
        break;
      end
    end
    @(negedge clock);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;
  int          seen;

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_mode = 2'b11;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    repeat (3) @(negedge clock);
    check_eq("rst_ready", {31'h0, mem_ready}, 32'h0);
    check_eq("rst_rdata", mem_rdata, 32'h0);
    check_eq("rst_error", {31'h0, mem_error}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    do_req(1'b0, 2'b11, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lt);
    check_eq("wr_lat", lt, LAT);
    check_eq("wr_err", {31'h0, er}, 32'h0);
    check_eq("wr_rdata", rd, 32'h0);
    check_eq("pulse_width", {31'h0, mem_ready}, 32'h0);
    do_req(1'b0, 2'b11, 32'h10, 32'h0, 4'h0, rd, er, lt);
    check_eq("rd_lat", lt, LAT);
    check_eq("rd_data", rd, 32'hDEADBEEF);
    check_eq("rd_err", {31'h0, er}, 32'h0);

    do_req(1'b0, 2'b11, 32'h24, 32'h11223344, 4'hF, rd, er, lt);
    do_req(1'b0, 2'b11, 32'h24, 32'hAABBCCDD, 4'b0101, rd, er, lt);
    check_eq("strb_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 2'b11, 32'h24, 32'h0, 4'h0, rd, er, lt);
    check_eq("strb_data", rd, 32'h11BB33DD);

    do_req(1'b0, 2'b11, 32'h1000, 32'h0, 4'h0, rd, er, lt);
    check_eq("oor_err", {31'h0, er}, 32'h1);
    check_eq("oor_rdata", rd, 32'h0);
    do_req(1'b0, 2'b11, 32'hFFC, 32'h0, 4'h0, rd, er, lt);
    check_eq("last_word_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 2'b11, 32'h2, 32'h0, 4'h0, rd, er, lt);
    check_eq("misalign_err", {31'h0, er}, 32'h1);
    check_eq("misalign_rdata", rd, 32'h0);
    do_req(1'b1, 2'b11, 32'h10, 32'h00000055, 4'h1, rd, er, lt);
    check_eq("fetch_st_err", {31'h0, er}, 32'h1);
    do_req(1'b1, 2'b11, 32'h10, 32'h0, 4'h0, rd, er, lt);
    check_eq("fetch_rd_err", {31'h0, er}, 32'h0);
    check_eq("fetch_unchanged", rd, 32'hDEADBEEF);
    do_req(1'b0, 2'b11, 32'hFFFFFFFC, 32'h0, 4'h0, rd, er, lt);
    check_eq("nowrap_err", {31'h0, er}, 32'h1);

    // Busy ignore: valid held high with a new address during WAIT.
    do_req(1'b0, 2'b11, 32'h40, 32'h0A0A0A0A, 4'hF, rd, er, lt);
    do_req(1'b0, 2'b11, 32'h44, 32'h0B0B0B0B, 4'hF, rd, er, lt);
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h40; mem_wstrb = 4'h0;
    @(posedge clock); #1;
    mem_addr = 32'h44;
    lt = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      if (mem_ready) begin lt = c; rd = mem_rdata; break; end
    end
    check_eq("busy_lat1", lt, LAT);
    check_eq("busy_data1", rd, 32'h0A0A0A0A);
    lt = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      if (mem_ready) begin lt = c; rd = mem_rdata; break; end
    end
    mem_valid = 1'b0;
    check_eq("busy_lat2", lt, LAT);
    check_eq("busy_data2", rd, 32'h0B0B0B0B);
    repeat (LAT + 1) @(negedge clock);

    // Reset one cycle after accept of a write.
    do_req(1'b0, 2'b11, 32'h20, 32'hCAFEF00D, 4'hF, rd, er, lt);
    mem_valid = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h12345678; mem_wstrb = 4'hF;
    @(posedge clock); #1;
    mem_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    @(negedge clock);
    if (mem_ready) seen++;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (mem_ready) seen++;
    end
    check_eq("rstwait_noready", seen, 0);
    do_req(1'b0, 2'b11, 32'h20, 32'h0, 4'h0, rd, er, lt);
    check_eq("rstwait_old", rd, 32'hCAFEF00D);

    do_req(1'b0, 2'b11, 32'hC, 32'h33333333, 4'hF, rd, er, lt);
    do_req(1'b0, 2'b00, 32'hC, 32'h55555555, 4'hF, rd, er, lt);
`ifdef TCM_UMODE_GUARD_EN
    check_eq("guard_u_err", {31'h0, er}, 32'h1);
    do_req(1'b0, 2'b00, 32'hC, 32'h0, 4'h0, rd, er, lt);
    check_eq("guard_u_rd_err", {31'h0, er}, 32'h0);
    check_eq("guard_u_data", rd, 32'h33333333);
    do_req(1'b0, 2'b11, 32'hC, 32'h66666666, 4'hF, rd, er, lt);
    check_eq("guard_m_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 2'b11, 32'hC, 32'h0, 4'h0, rd, er, lt);
    check_eq("guard_m_data", rd, 32'h66666666);
    do_req(1'b0, 2'b00, 32'h40, 32'h77777777, 4'hF, rd, er, lt);
    check_eq("guard_edge_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 2'b11, 32'h40, 32'h0, 4'h0, rd, er, lt);
    check_eq("guard_edge_data", rd, 32'h77777777);
`else
    check_eq("noguard_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 2'b11, 32'hC, 32'h0, 4'h0, rd, er, lt);
    check_eq("noguard_data", rd, 32'h55555555);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
